tile_fetch: RTL and testbench

- Read-side client of the tile BRAM. Drives its synchronous read port (rd_en/rd_address in, 16-bit rd_data out one cycle later).
- Converts a character request (code, glyph row, font bank, font height) into a tile-word read and selects the 8-pixel byte for that row.
- Buffers up to two glyph rows and shifts pixels out MSB-first to the video pixel pipeline under a per-pixel enable.

---
 rtl/xosera_pkg.sv | 48 ++++
 rtl/tile_pix_shift.sv | 122 ++++++++++++
 rtl/tile_fetch.sv | 124 ++++++++++++
 tb/tb_tile_fetch.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xosera_pkg.sv
// -----------------------------------------------------------------------------
// xosera_pkg
//   Shared types and helpers for the tile fetch path.
//   - TILE_AW      : tile memory word-address width (fixed address map).
//   - PIX_W        : pixel output width. It is 1 by default and 4 when
//                    TILE_FETCH_ATTR_EN is defined (attribute colour mode).
//   - font_size_t  : 8x8 / 8x16 glyph height.
//   - fetch_state_t: fetch FSM states.
//   - tile_addr()  : character request to tile word address.
// Optional feature macro: TILE_FETCH_ATTR_EN
// -----------------------------------------------------------------------------
package xosera_pkg;

  localparam int TILE_AW = 12;

`ifdef TILE_FETCH_ATTR_EN
  localparam int PIX_W = 4;
`else
  localparam int PIX_W = 1;
`endif

  typedef enum logic {
    FONT_8X8  = 1'b0,
    FONT_8X16 = 1'b1
  } font_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2
  } fetch_state_t;

  // Each word packs two glyph rows, so row[0] never reaches the address.
  // 8x16: 2K-word banks (bank[0] ignored), 8 words per glyph.
  // 8x8 : 1K-word banks, 4 words per glyph (row[3] ignored).
  function automatic logic [TILE_AW-1:0] tile_addr(
    input logic [1:0] bank,
    input logic [7:0] code,
    input logic [3:1] row,
    input font_size_t h16
  );
    if (h16 == FONT_8X16) begin
      return {bank[1], code, row[3:1]};
    end
    return {bank, code, row[2:1]};
  endfunction

endpackage

// File: rtl/tile_pix_shift.sv
// -----------------------------------------------------------------------------
// tile_pix_shift
//   8-pixel shifter with one byte of hold buffering. Pixels leave MSB-first.
//   Ports:
//     clk, reset_ni       clock, asynchronous active-low reset
//     load_i              captured byte is available this cycle
//     load_byte_i[7:0]    captured glyph row byte
//     load_attr_i[7:0]    attribute for that byte (TILE_FETCH_ATTR_EN only)
//     pix_en_i            consume one pixel
//     underflow_clr_i     clear the sticky underflow flag
//     hold_full_o         hold register occupied
//     pix_valid_o         shifter holds at least one pixel
//     pix_o[PIX_W-1:0]    current pixel (bit, or fg/bg colour with attributes)
//     underflow_o         sticky: pixel requested while empty
// Optional feature macro: TILE_FETCH_ATTR_EN
// -----------------------------------------------------------------------------
module tile_pix_shift
  import xosera_pkg::*;
(
  input  logic             clk,
  input  logic             reset_ni,
  input  logic             load_i,
  input  logic [7:0]       load_byte_i,
`ifdef TILE_FETCH_ATTR_EN
  input  logic [7:0]       load_attr_i,
`endif
  input  logic             pix_en_i,
  input  logic             underflow_clr_i,
  output logic             hold_full_o,
  output logic             pix_valid_o,
  output logic [PIX_W-1:0] pix_o,
  output logic             underflow_o
);

  logic [7:0] r_shift;
  logic [3:0] r_count;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic       r_underflow;
`ifdef TILE_FETCH_ATTR_EN
  logic [7:0] r_shift_attr;
  logic [7:0] r_hold_attr;
`endif

  logic w_consume;
  logic w_last;
  logic w_empty_next;

  assign pix_valid_o  = (r_count != 4'd0);
  assign hold_full_o  = r_hold_full;
  assign underflow_o  = r_underflow;
  assign w_consume    = pix_en_i & pix_valid_o;
  assign w_last       = w_consume & (r_count == 4'd1);
  // Shifter is free for a new byte at the next edge.
  assign w_empty_next = (r_count == 4'd0) | w_last;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_shift     <= '0;
      r_count     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_underflow <= 1'b0;
`ifdef TILE_FETCH_ATTR_EN
      r_shift_attr <= '0;
      r_hold_attr  <= '0;
`endif
    end else begin
      // The fetch side only accepts while hold is empty and keeps one read
      // outstanding, so a capture never coincides with a full hold.
      if (load_i && w_empty_next) begin
        r_shift <= load_byte_i;
        r_count <= 4'd8;
`ifdef TILE_FETCH_ATTR_EN
        r_shift_attr <= load_attr_i;
`endif
      end else if (w_last && r_hold_full) begin
        // Reload on the last pixel so the stream has no bubble.
        r_shift     <= r_hold;
        r_count     <= 4'd8;
        r_hold_full <= 1'b0;
`ifdef TILE_FETCH_ATTR_EN
        r_shift_attr <= r_hold_attr;
`endif
      end else if (w_consume) begin
        r_shift <= {r_shift[6:0], 1'b0};
        r_count <= r_count - 4'd1;
      end

      if (load_i && !w_empty_next) begin
        r_hold      <= load_byte_i;
        r_hold_full <= 1'b1;
`ifdef TILE_FETCH_ATTR_EN
        r_hold_attr <= load_attr_i;
`endif
      end

      // Set has priority over clear.
      if (pix_en_i && !pix_valid_o) begin
        r_underflow <= 1'b1;
      end else if (underflow_clr_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

  // NOTE: default assignment first so no path leaves pix_o unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    pix_o = '0;
    if (pix_valid_o) begin
`ifdef TILE_FETCH_ATTR_EN
      pix_o = r_shift[7] ? r_shift_attr[7:4] : r_shift_attr[3:0];
`else
      pix_o = r_shift[7];
`endif
    end
  end

endmodule

// File: rtl/tile_fetch.sv
// -----------------------------------------------------------------------------
// tile_fetch
//   Read-side client of the tile BRAM. Turns a character request into one
//   tile-word read, picks the glyph-row byte and hands it to the pixel shifter.
//   Parameter:
//     AWIDTH              tile word-address width, must equal TILE_AW (12)
//   Ports:
//     clk, reset_ni       clock (also the BRAM read clock), async active-low reset
//     char_valid_i/_ready_o  request handshake
//     char_code_i[7:0]    glyph index
//     tile_row_i[3:0]     glyph row
//     font_bank_i[1:0]    font bank
//     font_h16_i          1 = 8x16 font, 0 = 8x8 font
//     char_attr_i[7:0]    fg/bg attribute (TILE_FETCH_ATTR_EN only)
//     tm_rd_en_o, tm_rd_addr_o, tm_rd_data_i  BRAM read port (1-cycle latency)
//     pix_en_i            consume one pixel
//     pix_valid_o, pix_o  pixel output
//     underflow_o, underflow_clr_i  sticky underflow flag and its clear
// Optional feature macro: TILE_FETCH_ATTR_EN
// -----------------------------------------------------------------------------
module tile_fetch
  import xosera_pkg::*;
#(
  parameter int AWIDTH = TILE_AW
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              char_valid_i,
  output logic              char_ready_o,
  input  logic [7:0]        char_code_i,
  input  logic [3:0]        tile_row_i,
  input  logic [1:0]        font_bank_i,
  input  logic              font_h16_i,
`ifdef TILE_FETCH_ATTR_EN
  input  logic [7:0]        char_attr_i,
`endif
  output logic              tm_rd_en_o,
  output logic [AWIDTH-1:0] tm_rd_addr_o,
  input  logic [15:0]       tm_rd_data_i,
  input  logic              pix_en_i,
  output logic              pix_valid_o,
  output logic [PIX_W-1:0]  pix_o,
  output logic              underflow_o,
  input  logic              underflow_clr_i
);

  fetch_state_t      r_state;
  logic              r_rd_en;
  logic [AWIDTH-1:0] r_addr;
  logic              r_bsel;
`ifdef TILE_FETCH_ATTR_EN
  logic [7:0]        r_attr;
`endif

  logic       w_hold_full;
  logic       w_accept;
  logic       w_cap;
  logic [7:0] w_cap_byte;

  // Ready only when idle with free hold space, which caps reads in flight at one.
  assign char_ready_o = (r_state == ST_IDLE) & ~w_hold_full;
  assign w_accept     = char_valid_i & char_ready_o;
  assign tm_rd_en_o   = r_rd_en;
  assign tm_rd_addr_o = r_addr;
  assign w_cap        = (r_state == ST_CAP);
  // Even rows live in the high byte.
  assign w_cap_byte   = r_bsel ? tm_rd_data_i[7:0] : tm_rd_data_i[15:8];

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= ST_IDLE;
      r_rd_en <= 1'b0;
      r_addr  <= '0;
      r_bsel  <= 1'b0;
`ifdef TILE_FETCH_ATTR_EN
      r_attr  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= AWIDTH'(tile_addr(font_bank_i, char_code_i, tile_row_i[3:1],
                                         font_size_t'(font_h16_i)));
            r_bsel  <= tile_row_i[0];
`ifdef TILE_FETCH_ATTR_EN
            r_attr  <= char_attr_i;
`endif
            r_rd_en <= 1'b1;
            r_state <= ST_RD;
          end
        end
        ST_RD: begin
          // Address stays put after the strobe; only the enable drops.
          r_rd_en <= 1'b0;
          r_state <= ST_CAP;
        end
        ST_CAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_rd_en <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  tile_pix_shift u_shift (
    .clk             (clk),
    .reset_ni        (reset_ni),
    .load_i          (w_cap),
    .load_byte_i     (w_cap_byte),
`ifdef TILE_FETCH_ATTR_EN
    .load_attr_i     (r_attr),
`endif
    .pix_en_i        (pix_en_i),
    .underflow_clr_i (underflow_clr_i),
    .hold_full_o     (w_hold_full),
    .pix_valid_o     (pix_valid_o),
    .pix_o           (pix_o),
    .underflow_o     (underflow_o)
  );

endmodule

// File: tb/tb_tile_fetch.sv
`timescale 1ns/1ps
module tb_tile_fetch;
  import xosera_pkg::*;

  logic               clk = 1'b0;
  logic               reset_ni;
  logic               char_valid_i;
  logic               char_ready_o;
  logic [7:0]         char_code_i;
  logic [3:0]         tile_row_i;
  logic [1:0]         font_bank_i;
  logic               font_h16_i;
`ifdef TILE_FETCH_ATTR_EN
  logic [7:0]         char_attr_i;
`endif
  logic               tm_rd_en_o;
  logic [TILE_AW-1:0] tm_rd_addr_o;
  logic [15:0]        tm_rd_data_i;
  logic               pix_en_i;
  logic               pix_valid_o;
  logic [PIX_W-1:0]   pix_o;
  logic               underflow_o;
  logic               underflow_clr_i;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0]        mem [0:4095];
  logic [TILE_AW-1:0] exp_addr;   // address the DUT should currently present

  always #5 clk = ~clk;

  // Synchronous-read tile BRAM model.
  always @(posedge clk) if (tm_rd_en_o) tm_rd_data_i <= mem[tm_rd_addr_o];

  tile_fetch #(.AWIDTH(TILE_AW)) dut (
    .clk             (clk),
    .reset_ni        (reset_ni),
    .char_valid_i    (char_valid_i),
    .char_ready_o    (char_ready_o),
    .char_code_i     (char_code_i),
    .tile_row_i      (tile_row_i),
    .font_bank_i     (font_bank_i),
    .font_h16_i      (font_h16_i),
`ifdef TILE_FETCH_ATTR_EN
    .char_attr_i     (char_attr_i),
`endif
    .tm_rd_en_o      (tm_rd_en_o),
    .tm_rd_addr_o    (tm_rd_addr_o),
    .tm_rd_data_i    (tm_rd_data_i),
    .pix_en_i        (pix_en_i),
    .pix_valid_o     (pix_valid_o),
    .pix_o           (pix_o),
    .underflow_o     (underflow_o),
    .underflow_clr_i (underflow_clr_i)
  );

  // ---- reference model helpers (plain arithmetic from the address map) ----
  function automatic int ref_addr(input int bank, input int code, input int row, input bit h16);
    if (h16) return (bank / 2) * 2048 + code * 8 + row / 2;
    return bank * 1024 + code * 4 + (row % 8) / 2;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [15:0] word, input int row);
    return (row % 2 == 1) ? word[7:0] : word[15:8];
  endfunction

  function automatic logic [PIX_W-1:0] exp_pix(input logic b, input logic [7:0] attr);
`ifdef TILE_FETCH_ATTR_EN
    return b ? attr[7:4] : attr[3:0];
`else
    return PIX_W'(b ^ (attr[0] & 1'b0));
`endif
  endfunction

  task automatic drive_req(input logic [1:0] bank, input logic [7:0] code,
                           input logic [3:0] row, input logic h16, input logic [7:0] attr);
    font_bank_i  = bank;
    char_code_i  = code;
    tile_row_i   = row;
    font_h16_i   = h16;
`ifdef TILE_FETCH_ATTR_EN
    char_attr_i  = attr;
`endif
    char_valid_i = 1'b1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset_ni = 1'b0; char_valid_i = 1'b0; pix_en_i = 1'b0; underflow_clr_i = 1'b0;
    drive_req(2'd0, 8'd0, 4'd0, 1'b0, 8'd0); char_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (char_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", char_ready_o); else n_pass++;
    n_checks++; if (tm_rd_en_o !== 1'b0) $display("FAIL reset_rd_en got %b want 0", tm_rd_en_o); else n_pass++;
    n_checks++; if (tm_rd_addr_o !== '0) $display("FAIL reset_addr got %h want 000", tm_rd_addr_o); else n_pass++;
    n_checks++; if (pix_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", pix_valid_o); else n_pass++;
    n_checks++; if (pix_o !== '0) $display("FAIL reset_pix got %h want 0", pix_o); else n_pass++;
    n_checks++; if (underflow_o !== 1'b0) $display("FAIL reset_underflow got %b want 0", underflow_o); else n_pass++;
    reset_ni = 1'b1;
    exp_addr = '0;
    @(negedge clk);
  endtask

  // Single request into an idle, empty DUT; checks cycle-exact latency.
  task automatic fetch_and_check(input logic [1:0] bank, input logic [7:0] code, input logic [3:0] row,
                                 input logic h16, input logic [7:0] attr, input logic [TILE_AW-1:0] want_addr);
    logic [7:0]       byte_v;
    logic [PIX_W-1:0] want;
    n_checks++; if (char_ready_o !== 1'b1) $display("FAIL fetch_ready0 got %b want 1", char_ready_o); else n_pass++;
    drive_req(bank, code, row, h16, attr);
    @(negedge clk);                       // cycle 1
    char_valid_i = 1'b0;
    n_checks++; if (tm_rd_en_o !== 1'b1) $display("FAIL fetch_rd_en_c1 got %b want 1", tm_rd_en_o); else n_pass++;
    n_checks++; if (tm_rd_addr_o !== want_addr) $display("FAIL fetch_addr got %h want %h", tm_rd_addr_o, want_addr); else n_pass++;
    n_checks++; if (char_ready_o !== 1'b0) $display("FAIL fetch_ready_c1 got %b want 0", char_ready_o); else n_pass++;
    exp_addr = want_addr;
    @(negedge clk);                       // cycle 2
    n_checks++; if (tm_rd_en_o !== 1'b0) $display("FAIL fetch_rd_en_c2 got %b want 0", tm_rd_en_o); else n_pass++;
    n_checks++; if (tm_rd_addr_o !== exp_addr) $display("FAIL fetch_addr_hold got %h want %h", tm_rd_addr_o, exp_addr); else n_pass++;
    n_checks++; if (pix_valid_o !== 1'b0) $display("FAIL fetch_valid_c2 got %b want 0", pix_valid_o); else n_pass++;
    @(negedge clk);                       // cycle 3
    byte_v   = ref_byte(mem[want_addr], int'(row));
    pix_en_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want = exp_pix(byte_v[7-i], attr);
      n_checks++; if (pix_valid_o !== 1'b1) $display("FAIL fetch_valid px%0d got %b want 1", i, pix_valid_o); else n_pass++;
      n_checks++; if (pix_o !== want) $display("FAIL fetch_pix px%0d got %h want %h", i, pix_o, want); else n_pass++;
      n_checks++; if (tm_rd_en_o !== 1'b0) $display("FAIL fetch_rd_en_extra px%0d got %b want 0", i, tm_rd_en_o); else n_pass++;
      @(negedge clk);
    end
    pix_en_i = 1'b0;
    n_checks++; if (pix_valid_o !== 1'b0) $display("FAIL fetch_valid_end got %b want 0", pix_valid_o); else n_pass++;
    n_checks++; if (underflow_o !== 1'b0) $display("FAIL fetch_underflow got %b want 0", underflow_o); else n_pass++;
  endtask

  task automatic test_fetch_8x16();
    mem[12'h20A] = 16'hF00F;
    fetch_and_check(2'd0, 8'h41, 4'd5, 1'b1, 8'($urandom), 12'h20A);
    // bank[0] does not take part in the 8x16 address.
    mem[12'h20A] = 16'h6C93;
    fetch_and_check(2'd1, 8'h41, 4'd4, 1'b1, 8'($urandom), 12'h20A);
  endtask

  task automatic test_fetch_8x8();
    mem[12'hFFF] = 16'hA53C;
    fetch_and_check(2'd3, 8'hFF, 4'd6, 1'b0, 8'($urandom), 12'hFFF);
    // row[3] does not take part in the 8x8 address.
    fetch_and_check(2'd3, 8'hFF, 4'd15, 1'b0, 8'($urandom), 12'hFFF);
  endtask

  task automatic test_underflow();
    n_checks++; if (pix_valid_o !== 1'b0) $display("FAIL uf_pre_valid got %b want 0", pix_valid_o); else n_pass++;
    pix_en_i = 1'b1;
    n_checks++; if (pix_o !== '0) $display("FAIL uf_pix got %h want 0", pix_o); else n_pass++;
    @(negedge clk);
    pix_en_i = 1'b0;
    n_checks++; if (underflow_o !== 1'b1) $display("FAIL uf_set got %b want 1", underflow_o); else n_pass++;
    n_checks++; if (pix_valid_o !== 1'b0) $display("FAIL uf_valid got %b want 0", pix_valid_o); else n_pass++;
    n_checks++; if (pix_o !== '0) $display("FAIL uf_pix_after got %h want 0", pix_o); else n_pass++;
    pix_en_i = 1'b1; underflow_clr_i = 1'b1;
    @(negedge clk);
    pix_en_i = 1'b0; underflow_clr_i = 1'b0;
    n_checks++; if (underflow_o !== 1'b1) $display("FAIL uf_set_wins got %b want 1", underflow_o); else n_pass++;
    underflow_clr_i = 1'b1;
    @(negedge clk);
    underflow_clr_i = 1'b0;
    n_checks++; if (underflow_o !== 1'b0) $display("FAIL uf_clear got %b want 0", underflow_o); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    logic [7:0] code;
    pix_en_i = 1'b1;                       // raise underflow so reset has something to clear
    @(negedge clk);
    pix_en_i = 1'b0;
    drive_req(2'd2, 8'h5A, 4'd3, 1'b1, 8'h00);
    @(negedge clk);                        // RD cycle
    char_valid_i = 1'b0;
    n_checks++; if (tm_rd_en_o !== 1'b1) $display("FAIL rst_mid_rd_en got %b want 1", tm_rd_en_o); else n_pass++;
    #2 reset_ni = 1'b0;
    #1;
    n_checks++; if (char_ready_o !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", char_ready_o); else n_pass++;
    n_checks++; if (tm_rd_en_o !== 1'b0) $display("FAIL rst_mid_rd_en0 got %b want 0", tm_rd_en_o); else n_pass++;
    n_checks++; if (tm_rd_addr_o !== '0) $display("FAIL rst_mid_addr got %h want 000", tm_rd_addr_o); else n_pass++;
    n_checks++; if (pix_valid_o !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", pix_valid_o); else n_pass++;
    n_checks++; if (pix_o !== '0) $display("FAIL rst_mid_pix got %h want 0", pix_o); else n_pass++;
    n_checks++; if (underflow_o !== 1'b0) $display("FAIL rst_mid_underflow got %b want 0", underflow_o); else n_pass++;
    @(negedge clk);
    reset_ni = 1'b1;
    exp_addr = '0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (pix_valid_o !== 1'b0) $display("FAIL rst_mid_stale cyc%0d got %b want 0", i, pix_valid_o); else n_pass++;
      @(negedge clk);
    end
    code = 8'($urandom);
    fetch_and_check(2'd1, code, 4'd9, 1'b0, 8'($urandom), TILE_AW'(ref_addr(1, int'(code), 9, 1'b0)));
  endtask

  // Random traffic against a queue model: the queue holds every pixel captured
  // and not yet consumed; a fetch lands 2 edges after its accept; the hold
  // register is full exactly when more than 8 pixels are queued.
  task automatic test_back_to_back(input int n_cycles, input bit stream);
    logic [PIX_W-1:0]   q[$];
    int                 stage = 0;
    bit                 uf_exp = 1'b0;
    bit                 acc;
    bit                 started = 1'b0;
    int                 gaps = 0;
    logic [7:0]         pbyte = '0, pattr = '0, attr;
    logic [TILE_AW-1:0] paddr;
    logic [PIX_W-1:0]   want_pix;
    logic [1:0]         bank;
    logic [7:0]         code;
    logic [3:0]         row;
    logic               h16;
    underflow_clr_i = 1'b1;
    @(negedge clk);
    underflow_clr_i = 1'b0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      want_pix = (q.size() != 0) ? q[0] : '0;
      n_checks++; if (char_ready_o !== (stage == 0 && q.size() <= 8)) $display("FAIL b2b_ready cyc%0d got %b queued %0d", cyc, char_ready_o, q.size()); else n_pass++;
      n_checks++; if (tm_rd_en_o !== (stage == 2)) $display("FAIL b2b_rd_en cyc%0d got %b want %b", cyc, tm_rd_en_o, stage == 2); else n_pass++;
      n_checks++; if (tm_rd_addr_o !== exp_addr) $display("FAIL b2b_addr cyc%0d got %h want %h", cyc, tm_rd_addr_o, exp_addr); else n_pass++;
      n_checks++; if (pix_valid_o !== (q.size() != 0)) $display("FAIL b2b_valid cyc%0d got %b queued %0d", cyc, pix_valid_o, q.size()); else n_pass++;
      n_checks++; if (pix_o !== want_pix) $display("FAIL b2b_pix cyc%0d got %h want %h", cyc, pix_o, want_pix); else n_pass++;
      n_checks++; if (underflow_o !== uf_exp) $display("FAIL b2b_underflow cyc%0d got %b want %b", cyc, underflow_o, uf_exp); else n_pass++;
      if (q.size() != 0) started = 1'b1;
      if (stream && started && pix_valid_o !== 1'b1) gaps++;

      bank = 2'($urandom); code = 8'($urandom); row = 4'($urandom); h16 = 1'($urandom); attr = 8'($urandom);
      drive_req(bank, code, row, h16, attr);
      char_valid_i    = stream ? 1'b1 : ($urandom_range(0, 2) == 0);
      pix_en_i        = stream ? started : ($urandom_range(0, 3) != 0);
      underflow_clr_i = stream ? 1'b0 : ($urandom_range(0, 7) == 0);
      acc = char_valid_i && stage == 0 && q.size() <= 8;
      if (acc) begin
        paddr = TILE_AW'(ref_addr(int'(bank), int'(code), int'(row), h16));
        pbyte = ref_byte(mem[paddr], int'(row));
        pattr = attr;
      end

      @(posedge clk);
      if (pix_en_i && q.size() == 0) uf_exp = 1'b1;
      else if (underflow_clr_i) uf_exp = 1'b0;
      if (pix_en_i && q.size() != 0) void'(q.pop_front());
      if (stage == 1) for (int b = 7; b >= 0; b--) q.push_back(exp_pix(pbyte[b], pattr));
      if (stage > 0) stage--;
      if (acc) begin stage = 2; exp_addr = paddr; end
      @(negedge clk);
    end
    if (stream) begin
      n_checks++; if (gaps != 0) $display("FAIL b2b_gap got %0d empty cycles want 0", gaps); else n_pass++;
    end
    char_valid_i = 1'b0; pix_en_i = 1'b1; underflow_clr_i = 1'b0;
    repeat (40) @(negedge clk);
    pix_en_i = 1'b0; underflow_clr_i = 1'b1;
    @(negedge clk);
    underflow_clr_i = 1'b0;
  endtask

`ifdef TILE_FETCH_ATTR_EN
  task automatic test_attr();
    logic [3:0] want;
    mem[12'h040] = 16'h80C3;               // 8x8, bank 0, code 0x10, row 0
    drive_req(2'd0, 8'h10, 4'd0, 1'b0, 8'h2A);
    @(negedge clk);
    char_valid_i = 1'b0;
    n_checks++; if (tm_rd_addr_o !== 12'h040) $display("FAIL attr_addr got %h want 040", tm_rd_addr_o); else n_pass++;
    exp_addr = 12'h040;
    repeat (2) @(negedge clk);
    pix_en_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want = (i == 0) ? 4'h2 : 4'hA;
      n_checks++; if (pix_o !== want) $display("FAIL attr_pix px%0d got %h want %h", i, pix_o, want); else n_pass++;
      @(negedge clk);
    end
    n_checks++; if (pix_o !== 4'h0) $display("FAIL attr_underflow_pix got %h want 0", pix_o); else n_pass++;
    @(negedge clk);
    pix_en_i = 1'b0;
    underflow_clr_i = 1'b1;
    @(negedge clk);
    underflow_clr_i = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    tm_rd_data_i = '0;
    test_reset();
    test_fetch_8x16();
    test_fetch_8x8();
    test_underflow();
    test_reset_mid_fetch();
    test_back_to_back(80, 1'b1);
    test_back_to_back(600, 1'b0);
`ifdef TILE_FETCH_ATTR_EN
    test_attr();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
